voice_sched: RTL and testbench

- Per-frame scheduler that shares one sine source engine between NUM_VOICES voices.
- On each rising pblrc edge it snapshots every voice's freq/vol/enable and requests one sample per enabled voice from the engine over a req/ack handshake.
- It sums the returned samples with saturation and presents one mixed 16-bit sample per frame to the codec serializer.
- Sits between the PS-written voice control registers and the src_sine engine, all in the mclk domain.

---
 rtl/voice_sched.sv | 178 +++++++++++++++++
 tb/tb_voice_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sched.sv
// Frame scheduler sharing one sine engine across NUM_VOICES voices.
// In: mclk, rst(n), pblrc, voice_*; eng_ack/eng_sample from engine.
// Out: eng_req/voice/freq/vol, mix_sample/mix_valid, overrun, timeout_err.
module voice_sched #(
   parameter int NUM_VOICES    = 4,
   parameter int FREQ_RES_BITS = 8,
   parameter int VOLUME_BITS   = 8,
   parameter int ACK_TIMEOUT   = 32
) (
   input  logic                                mclk,
   input  logic                                rst,
   input  logic                                pblrc,
   input  logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
   input  logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_vol,
   input  logic [NUM_VOICES-1:0]               voice_en,
   output logic                                eng_req,
   output logic [2:0]                          eng_voice,
   output logic [FREQ_RES_BITS-1:0]            eng_freq,
   output logic [VOLUME_BITS-1:0]              eng_vol,
   input  logic                                eng_ack,
   input  logic [15:0]                         eng_sample,
   output logic [15:0]                         mix_sample,
   output logic                                mix_valid,
   output logic                                overrun,
   output logic                                timeout_err
);

   localparam int ACC_W = 16 + $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);

   typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_e;

   state_e state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [15:0] mix_q, mix_d;
   logic ovr_q, ovr_d;
   logic tmo_q, tmo_d;
   logic pb_meta_q, pb_sync_q, pb_prev_q, start_q;
   logic [NUM_VOICES*FREQ_RES_BITS-1:0] snap_freq_q;
   logic [NUM_VOICES*VOLUME_BITS-1:0] snap_vol_q;
   logic [NUM_VOICES-1:0] snap_en_q;

   logic snap_ld;
   logic cur_en;
   logic [FREQ_RES_BITS-1:0] cur_freq;
   logic [VOLUME_BITS-1:0] cur_vol;
   logic signed [ACC_W-1:0] samp_ext;
   logic [15:0] sat;

   // start is the registered edge, so a frame begins 3 mclk after the rise
   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         pb_meta_q <= 1'b0;
         pb_sync_q <= 1'b0;
         pb_prev_q <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         pb_meta_q <= pblrc;
         pb_sync_q <= pb_meta_q;
         pb_prev_q <= pb_sync_q;
         start_q   <= pb_sync_q & ~pb_prev_q;
      end
   end

   always_comb begin
      cur_en   = 1'b0;
      cur_freq = '0;
      cur_vol  = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (idx_q == 4'(v)) begin
            cur_en   = snap_en_q[v];
            cur_freq = snap_freq_q[v*FREQ_RES_BITS +: FREQ_RES_BITS];
            cur_vol  = snap_vol_q[v*VOLUME_BITS +: VOLUME_BITS];
         end
      end
   end

   assign samp_ext = ACC_W'($signed(eng_sample));

   always_comb begin
      if (acc_q > MAXV)      sat = 16'h7fff;
      else if (acc_q < MINV) sat = 16'h8000;
      else                   sat = acc_q[15:0];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mix_d   = mix_q;
      tmo_d   = tmo_q;
      ovr_d   = ovr_q;
      snap_ld = 1'b0;
      // any start outside IDLE (including DONE) is dropped
      if (start_q && state_q != IDLE) ovr_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (start_q) begin
               snap_ld = 1'b1;
               acc_d   = '0;
               idx_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (idx_q == 4'(NUM_VOICES)) begin
               state_d = DONE;
            end else if (!cur_en) begin
               idx_d = idx_q + 4'd1;
            end else begin
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (eng_ack) begin
               acc_d   = acc_q + samp_ext;
               idx_d   = idx_q + 4'd1;
               state_d = SCAN;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               tmo_d   = 1'b1;
               idx_d   = idx_q + 4'd1;
               state_d = SCAN;
            end
         end
         DONE: begin
            mix_d   = sat;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mix_q       <= '0;
         tmo_q       <= 1'b0;
         ovr_q       <= 1'b0;
         snap_freq_q <= '0;
         snap_vol_q  <= '0;
         snap_en_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mix_q   <= mix_d;
         tmo_q   <= tmo_d;
         ovr_q   <= ovr_d;
         if (snap_ld) begin
            snap_freq_q <= voice_freq;
            snap_vol_q  <= voice_vol;
            snap_en_q   <= voice_en;
         end
      end
   end

   // engine outputs are held at 0 outside REQ
   assign eng_req     = (state_q == REQ);
   assign eng_voice   = eng_req ? idx_q[2:0] : 3'd0;
   assign eng_freq    = eng_req ? cur_freq : '0;
   assign eng_vol     = eng_req ? cur_vol : '0;
   assign mix_valid   = (state_q == DONE);
   assign mix_sample  = mix_valid ? sat : mix_q;
   assign overrun     = ovr_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_voice_sched.sv
// Directed bench for voice_sched with a behavioural engine model.
// Engine acks after lat cycles unless the voice is marked noack.
module tb_voice_sched;

   logic mclk, rst, pblrc;
   logic [31:0] voice_freq, voice_vol;
   logic [3:0] voice_en;
   logic eng_req, eng_ack;
   logic [2:0] eng_voice;
   logic [7:0] eng_freq, eng_vol;
   logic [15:0] eng_sample, mix_sample;
   logic mix_valid, overrun, timeout_err;

   voice_sched dut (
      .mclk(mclk), .rst(rst), .pblrc(pblrc),
      .voice_freq(voice_freq), .voice_vol(voice_vol),
      .voice_en(voice_en),
      .eng_req(eng_req), .eng_voice(eng_voice),
      .eng_freq(eng_freq), .eng_vol(eng_vol),
      .eng_ack(eng_ack), .eng_sample(eng_sample),
      .mix_sample(mix_sample), .mix_valid(mix_valid),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   int n_chk = 0;
   int n_fail = 0;
   int samp[4];
   bit [3:0] noack;
   int lat;
   int n_valid, n_req, n_drop, n_unstable, n_badmix, seq;
   int req_cyc[4];
   int mix_last, mix_exp;
   logic [7:0] freq_seen[4];
   logic prev_req;
   logic [2:0] pv;
   logic [7:0] pf, pvol;
   int wcnt;

   task automatic chk(input string tag,
                      input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      n_valid = 0; n_req = 0; n_drop = 0;
      n_unstable = 0; n_badmix = 0; seq = 0;
      for (int i = 0; i < 4; i++) req_cyc[i] = 0;
   endtask

   // monitor + engine model, sampled 1 time unit after each edge
   initial begin
      eng_ack = 0; eng_sample = 0; wcnt = 0;
      prev_req = 0; pv = 0; pf = 0; pvol = 0;
      forever begin
         @(posedge mclk); #1;
         if (mix_valid) begin
            n_valid++;
            mix_last = int'($signed(mix_sample));
            if (mix_last != mix_exp) n_badmix++;
         end
         if (eng_req && !prev_req) begin
            n_req++;
            seq = seq * 10 + int'(eng_voice) + 1;
            freq_seen[eng_voice[1:0]] = eng_freq;
         end
         if (eng_req) req_cyc[eng_voice[1:0]]++;
         if (prev_req && eng_req &&
             (eng_voice != pv || eng_freq != pf ||
              eng_vol != pvol)) n_unstable++;
         if (prev_req && !eng_req && !eng_ack) n_drop++;
         prev_req = eng_req;
         pv = eng_voice; pf = eng_freq; pvol = eng_vol;
         eng_ack = 0;
         if (eng_req) begin
            if (wcnt == lat - 1 && !noack[eng_voice[1:0]]) begin
               eng_ack = 1;
               eng_sample = 16'(samp[eng_voice[1:0]]);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic run_frame(input bit mid);
      int n0;
      n0 = n_valid;
      @(negedge mclk) pblrc = 1;
      for (int i = 0; i < 400 && n_valid == n0; i++) begin
         @(negedge mclk);
         if (i == 10) pblrc = 0;
         if (mid && i == 8) begin
            voice_en = 4'h0;
            voice_freq = '0;
         end
      end
      pblrc = 0;
      chk("frame_done", int'(n_valid != n0), 1);
      repeat (5) @(negedge mclk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 0; pblrc = 0;
      voice_freq = 32'h44332211;
      voice_vol = 32'h88776655;
      voice_en = 4'hf;
      lat = 2; noack = 0; mix_exp = 0; mix_last = 0;
      samp = '{1000, -200, 300, 50};
      clr_mon();
      repeat (3) @(negedge mclk);
      chk("rst_req", eng_req, 0);
      chk("rst_valid", mix_valid, 0);
      chk("rst_mix", mix_sample, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_tmo", timeout_err, 0);
      rst = 1;
      repeat (3) @(negedge mclk);

      // four voices, registers changed mid-frame
      clr_mon();
      run_frame(1);
      chk("t1_mix", mix_last, 1150);
      chk("t1_valid", n_valid, 1);
      chk("t1_nreq", n_req, 4);
      chk("t1_seq", seq, 1234);
      chk("t1_drop", n_drop, 0);
      chk("t1_stable", n_unstable, 0);
      chk("t1_freq3", freq_seen[3], 8'h44);
      repeat (10) @(negedge mclk);
      chk("t1_hold", $signed(mix_sample), 1150);
      voice_freq = 32'h44332211;

      // positive and negative saturation
      voice_en = 4'b1001;
      samp = '{30000, 7, 7, 30000};
      clr_mon();
      run_frame(0);
      chk("sat_pos", mix_last, 32767);
      chk("sat_nreq", n_req, 2);
      chk("sat_seq", seq, 14);
      samp = '{-30000, 7, 7, -30000};
      clr_mon();
      run_frame(0);
      chk("sat_neg", mix_last, -32768);
      chk("sat_nreq2", n_req, 2);

      // no enabled voices
      voice_en = 4'h0;
      mix_last = 99;
      clr_mon();
      run_frame(0);
      chk("none_mix", mix_last, 0);
      chk("none_valid", n_valid, 1);
      chk("none_nreq", n_req, 0);

      // voice 1 never acked
      voice_en = 4'hf;
      samp = '{100, 555, 100, 100};
      noack = 4'b0010;
      clr_mon();
      run_frame(0);
      chk("tmo_mix", mix_last, 300);
      chk("tmo_flag", timeout_err, 1);
      chk("tmo_cyc1", req_cyc[1], 32);
      chk("tmo_cyc0", req_cyc[0], 2);
      chk("tmo_drop", n_drop, 1);
      chk("tmo_ovr", overrun, 0);

      // slow engine vs. fast frames: every third rise is served
      noack = 0; lat = 31;
      samp = '{1000, -200, 300, 50};
      mix_exp = 1150;
      clr_mon();
      for (int k = 0; k < 10; k++) begin
         pblrc = 1;
         repeat (24) @(negedge mclk);
         pblrc = 0;
         repeat (24) @(negedge mclk);
      end
      repeat (200) @(negedge mclk);
      chk("ovr_flag", overrun, 1);
      chk("ovr_valid", n_valid, 4);
      chk("ovr_badmix", n_badmix, 0);
      chk("ovr_drop", n_drop, 0);

      // async reset while a request is outstanding
      lat = 20;
      @(negedge mclk) pblrc = 1;
      for (int i = 0; i < 50 && !eng_req; i++)
         @(negedge mclk);
      chk("rq_seen", eng_req, 1);
      @(posedge mclk);
      #2 rst = 0;
      #1;
      chk("rq_drop", eng_req, 0);
      chk("rq_ovr", overrun, 0);
      chk("rq_tmo", timeout_err, 0);
      pblrc = 0;
      repeat (3) @(negedge mclk);
      rst = 1;
      repeat (3) @(negedge mclk);
      lat = 2;
      clr_mon();
      run_frame(0);
      chk("rq_mix", mix_last, 1150);
      chk("rq_valid", n_valid, 1);
      chk("rq_ovr2", overrun, 0);
      chk("rq_tmo2", timeout_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
